// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I execute-stage ALU.
// Decodes opcode/funct3/bit30 into a 4-bit operation code (combinational ALUop)
// and registers the 32-bit result (one cycle of latency, asynchronous active-low reset).
// Optional macro ALU_ZERO_FLAG_EN adds a registered Zero output (reset value 1).
module alu_exec_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            Clock,
   input  logic            Reset_n,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct,
   input  logic            add_rshift_type,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic [3:0]      ALUop,
   output logic [XLEN-1:0] Out
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic            Zero
`endif
);

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLT   = 4'd5,
      ALU_SLTU  = 4'd6,
      ALU_SLL   = 4'd7,
      ALU_SRA   = 4'd8,
      ALU_SRL   = 4'd9,
      ALU_COPYB = 4'd10,
      ALU_XXX   = 4'd15
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   alu_op_e         op;
   logic [4:0]      shamt;
   logic [XLEN-1:0] res_d;
   logic [XLEN-1:0] out_q;

   assign shamt = B[4:0];
   assign ALUop = op;
   assign Out   = out_q;

   // Decode instruction fields into an ALU operation
   always_comb begin
      op = ALU_XXX;
      case (opcode)
         OPC_OP, OPC_OPIMM: begin
            case (funct)
               // bit30 only selects SUB for register-register ops; ADDI ignores it
               3'b000:  op = (opcode == OPC_OP && add_rshift_type) ? ALU_SUB : ALU_ADD;
               3'b001:  op = ALU_SLL;
               3'b010:  op = ALU_SLT;
               3'b011:  op = ALU_SLTU;
               3'b100:  op = ALU_XOR;
               3'b101:  op = add_rshift_type ? ALU_SRA : ALU_SRL;
               3'b110:  op = ALU_OR;
               default: op = ALU_AND;
            endcase
         end
         OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_AUIPC: op = ALU_ADD;
         OPC_LUI: op = ALU_COPYB;
         default: op = ALU_XXX;
      endcase
   end

   // Compute the result for the decoded operation
   always_comb begin
      res_d = '0;
      case (op)
         ALU_ADD:   res_d = A + B;
         ALU_SUB:   res_d = A - B;
         ALU_AND:   res_d = A & B;
         ALU_OR:    res_d = A | B;
         ALU_XOR:   res_d = A ^ B;
         ALU_SLT:   res_d = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
         ALU_SLTU:  res_d = {{(XLEN-1){1'b0}}, (A < B)};
         ALU_SLL:   res_d = A << shamt;
         ALU_SRA:   res_d = $unsigned($signed(A) >>> shamt);
         ALU_SRL:   res_d = A >> shamt;
         ALU_COPYB: res_d = B;
         default:   res_d = '0;
      endcase
   end

   // Capture the result every cycle; reset clears it asynchronously
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         out_q <= '0;
      end else begin
         out_q <= res_d;
      end
   end

`ifdef ALU_ZERO_FLAG_EN
   logic zero_q;
   assign Zero = zero_q;

   // Zero flag tracks the captured result; reset matches the cleared result
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         zero_q <= 1'b1;
      end else begin
         zero_q <= (res_d == '0);
      end
   end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: self-checking bench for alu_exec_unit with directed and random stimulus.
module tb_alu_exec_unit;

   logic        Clock;
   logic        Reset_n;
   logic [6:0]  opcode;
   logic [2:0]  funct;
   logic        add_rshift_type;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  ALUop;
   logic [31:0] Out;
`ifdef ALU_ZERO_FLAG_EN
   logic        Zero;
`endif

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.XLEN(32)) dut (
      .Clock(Clock),
      .Reset_n(Reset_n),
      .opcode(opcode),
      .funct(funct),
      .add_rshift_type(add_rshift_type),
      .A(A),
      .B(B),
      .ALUop(ALUop),
      .Out(Out)
`ifdef ALU_ZERO_FLAG_EN
      ,
      .Zero(Zero)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Reference decode from the instruction tables
   function automatic logic [3:0] ref_op(input logic [6:0] o, input logic [2:0] f, input logic t);
      int tbl[8] = '{0, 7, 5, 6, 4, 9, 3, 2};
      if (o == 7'b0110011 || o == 7'b0010011) begin
         if (f == 3'd0) return (o == 7'b0110011 && t) ? 4'd1 : 4'd0;
         if (f == 3'd5) return t ? 4'd8 : 4'd9;
         return 4'(tbl[f]);
      end
      if (o == 7'b0000011 || o == 7'b0100011 || o == 7'b1100011 ||
          o == 7'b1101111 || o == 7'b1100111 || o == 7'b0010111) return 4'd0;
      if (o == 7'b0110111) return 4'd10;
      return 4'd15;
   endfunction

   // Reference result using plain arithmetic
   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh = b[4:0];
      case (op)
         4'd0:  return a + b;
         4'd1:  return a + (~b) + 32'd1;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd6:  return (a < b) ? 32'd1 : 32'd0;
         4'd7:  return a << sh;
         4'd8:  return a[31] ? ~((~a) >> sh) : (a >> sh);
         4'd9:  return a >> sh;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   // Apply one operation at a falling edge and wait until its result is captured
   task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic t,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge Clock);
      opcode = o; funct = f; add_rshift_type = t; A = a; B = b;
      @(negedge Clock);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      opcode = 7'b0110011; funct = 3'd0; add_rshift_type = 1'b0; A = 32'd5; B = 32'd7;
      repeat (3) @(negedge Clock);
      checks++;
      if (Out !== 32'd0) begin errors++; $display("FAIL reset_hold: Out=%h expected %h", Out, 32'd0); end
`ifdef ALU_ZERO_FLAG_EN
      checks++;
      if (Zero !== 1'b1) begin errors++; $display("FAIL reset_zero: Zero=%b expected 1", Zero); end
`endif
      checks++;
      if (ALUop !== 4'd0) begin errors++; $display("FAIL reset_aluop: ALUop=%0d expected 0", ALUop); end
      Reset_n = 1'b1;
      @(negedge Clock);
      checks++;
      if (Out !== 32'h0000_000C) begin errors++; $display("FAIL reset_release: Out=%h expected %h", Out, 32'h0000_000C); end
      // asynchronous assertion between edges
      @(posedge Clock);
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if (Out !== 32'd0) begin errors++; $display("FAIL reset_async: Out=%h expected %h", Out, 32'd0); end
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   task automatic test_rtype_add_sub();
      drive(7'b0110011, 3'd0, 1'b1, 32'h3, 32'h5);
      checks++;
      if (ALUop !== 4'd1) begin errors++; $display("FAIL sub_aluop: ALUop=%0d expected 1", ALUop); end
      checks++;
      if (Out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_out: Out=%h expected FFFFFFFE", Out); end
      drive(7'b0110011, 3'd0, 1'b0, 32'h3, 32'h5);
      checks++;
      if (Out !== 32'h8) begin errors++; $display("FAIL add_out: Out=%h expected 00000008", Out); end
      drive(7'b0110011, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1);
      checks++;
      if (Out !== 32'h0) begin errors++; $display("FAIL add_wrap: Out=%h expected 00000000", Out); end
   endtask

   task automatic test_itype();
      drive(7'b0010011, 3'd0, 1'b1, 32'd10, 32'd3);
      checks++;
      if (ALUop !== 4'd0) begin errors++; $display("FAIL addi_aluop: ALUop=%0d expected 0", ALUop); end
      checks++;
      if (Out !== 32'hD) begin errors++; $display("FAIL addi_out: Out=%h expected 0000000D", Out); end
   endtask

   task automatic test_shifts();
      drive(7'b0110011, 3'd5, 1'b1, 32'h8000_0000, 32'h24);
      checks++;
      if (Out !== 32'hF800_0000) begin errors++; $display("FAIL sra_out: Out=%h expected F8000000", Out); end
      drive(7'b0110011, 3'd5, 1'b0, 32'h8000_0000, 32'h24);
      checks++;
      if (Out !== 32'h0800_0000) begin errors++; $display("FAIL srl_out: Out=%h expected 08000000", Out); end
      drive(7'b0010011, 3'd1, 1'b0, 32'h1234_5678, 32'hFFFF_FFE0);
      checks++;
      if (Out !== 32'h1234_5678) begin errors++; $display("FAIL sll_zero: Out=%h expected 12345678", Out); end
   endtask

   task automatic test_compare();
      drive(7'b0110011, 3'd2, 1'b0, 32'h8000_0000, 32'h1);
      checks++;
      if (Out !== 32'h1) begin errors++; $display("FAIL slt_out: Out=%h expected 00000001", Out); end
      drive(7'b0110011, 3'd3, 1'b0, 32'h8000_0000, 32'h1);
      checks++;
      if (Out !== 32'h0) begin errors++; $display("FAIL sltu_out: Out=%h expected 00000000", Out); end
   endtask

   task automatic test_other_opcodes();
      drive(7'b0110111, 3'd0, 1'b0, 32'h1234, 32'hABCD_E000);
      checks++;
      if (Out !== 32'hABCD_E000) begin errors++; $display("FAIL lui_out: Out=%h expected ABCDE000", Out); end
      drive(7'b0100011, 3'd2, 1'b0, 32'h100, 32'hFFFF_FFFC);
      checks++;
      if (Out !== 32'h0000_00FC) begin errors++; $display("FAIL store_out: Out=%h expected 000000FC", Out); end
      drive(7'b1111111, 3'd0, 1'b0, 32'h55, 32'h66);
      checks++;
      if (ALUop !== 4'd15) begin errors++; $display("FAIL xxx_aluop: ALUop=%0d expected 15", ALUop); end
      checks++;
      if (Out !== 32'h0) begin errors++; $display("FAIL xxx_out: Out=%h expected 00000000", Out); end
   endtask

   task automatic test_random();
      logic [6:0] opc_list[11] = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0000011,
                                  7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111};
      for (int i = 0; i < 200; i++) begin
         logic [6:0]  o;
         logic [2:0]  f;
         logic        t;
         logic [31:0] a, b, exp;
         logic [3:0]  eop;
         o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opc_list[$urandom_range(0, 10)];
         f = 3'($urandom); t = 1'($urandom);
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
         eop = ref_op(o, f, t);
         exp = ref_res(eop, a, b);
         drive(o, f, t, a, b);
         checks++;
         if (ALUop !== eop) begin errors++; $display("FAIL rand_aluop[%0d]: opc=%b f=%0d t=%b ALUop=%0d expected %0d", i, o, f, t, ALUop, eop); end
         checks++;
         if (Out !== exp) begin errors++; $display("FAIL rand_out[%0d]: op=%0d A=%h B=%h Out=%h expected %h", i, eop, a, b, Out, exp); end
`ifdef ALU_ZERO_FLAG_EN
         checks++;
         if (Zero !== (exp == 32'd0)) begin errors++; $display("FAIL rand_zero[%0d]: Zero=%b expected %b", i, Zero, (exp == 32'd0)); end
`endif
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] expq[$];
      for (int i = 0; i < 60; i++) begin
         logic [6:0] o;
         logic [2:0] f;
         logic       t;
         logic [31:0] a, b;
         @(negedge Clock);
         if (expq.size() > 0) begin
            logic [31:0] e;
            e = expq.pop_front();
            checks++;
            if (Out !== e) begin errors++; $display("FAIL b2b_out[%0d]: Out=%h expected %h", i, Out, e); end
         end
         o = ($urandom_range(0, 1) == 0) ? 7'b0110011 : 7'b0010011;
         f = 3'($urandom); t = 1'($urandom);
         a = $urandom; b = $urandom;
         opcode = o; funct = f; add_rshift_type = t; A = a; B = b;
         expq.push_back(ref_res(ref_op(o, f, t), a, b));
      end
      @(negedge Clock);
      checks++;
      if (Out !== expq[0]) begin errors++; $display("FAIL b2b_last: Out=%h expected %h", Out, expq[0]); end
   endtask

   initial begin
      test_reset();
      test_rtype_add_sub();
      test_itype();
      test_shifts();
      test_compare();
      test_other_opcodes();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- RV32I integer execute block: decodes opcode/funct/add_rshift_type into a 4-bit ALU operation, then computes a 32-bit result from operands A and B.
- Sits in the execute stage between the operand muxes and the writeback/memory-address path.
- ALUop is exposed combinationally; the result is registered, one cycle of latency.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the shift amount is B[4:0].

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- opcode  input  7  instruction opcode field [6:0].
- funct  input  3  instruction funct3 field.
- add_rshift_type  input  1  instruction bit 30 (funct7[5]): selects SUB vs ADD and SRA vs SRL.
- A  input  32  operand A.
- B  input  32  operand B (register or immediate).
- ALUop  output  4  decoded operation, combinational from opcode/funct/add_rshift_type.
- Out  output  32  registered result.

Behaviour:
- ALUop encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRA=8, SRL=9, COPY_B=10, XXX=15. Codes 11-14 are unused.
- Decode for R-type, opcode 0110011, by funct:
  - 000: SUB if add_rshift_type=1, else ADD.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRA if add_rshift_type=1, else SRL.
  - 110: OR. 111: AND.
- Decode for I-type ALU, opcode 0010011:
  - Same mapping as R-type, except funct 000 is always ADD; add_rshift_type is ignored for ADDI.
  - funct 101 uses add_rshift_type for SRAI vs SRLI.
- Opcodes that decode to ADD regardless of funct: load 0000011, store 0100011, branch 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111.
- LUI 0110111 decodes to COPY_B.
- Any other opcode decodes to XXX.
- Result functions:
  - ADD/SUB: modulo 2^32, no overflow flag.
  - AND/OR/XOR: bitwise.
  - SLT: 1 if signed A < signed B, else 0.
  - SLTU: unsigned compare, same 1/0 result.
  - SLL/SRL: logical shift by B[4:0].
  - SRA: arithmetic shift by B[4:0], sign-filled.
  - COPY_B: outputs B.
  - XXX or an unused code: outputs 0.
- Timing:
  - Result is computed combinationally and captured into Out on every rising Clock edge. There is no enable and no stall.
  - Inputs applied before edge N appear on Out after edge N.
- Reset:
  - Reset_n low forces Out=0 immediately (asynchronous) and holds it while asserted.
  - Release is synchronised internally to the next edge; the first capture occurs on the first rising edge with Reset_n high.
  - ALUop is unaffected by reset.
- Boundaries:
  - Shift by 0 returns A unchanged.
  - B[31:5] is ignored for shifts.
  - SLT of 0x80000000 vs 0x00000001 is 1; SLTU of the same pair is 0.
  - 0xFFFFFFFF + 1 wraps to 0.

Optional Feature:
- Macro: ALU_ZERO_FLAG_EN.
- When defined, add output port Zero (1 bit), registered alongside Out. Zero=1 when the newly captured result is 0x00000000. Reset value is 1.
- When undefined, the port does not exist and no extra logic is built.

Test Plan:
- Reset: hold Reset_n=0 with ADD A=5 B=7 and clock running -> Out=0. Release, one edge later -> Out=0x0000000C.
- R-type opcode 0110011, funct 000:
  - add_rshift_type=1, A=0x00000003, B=0x00000005 -> ALUop=1, Out=0xFFFFFFFE one cycle later.
  - add_rshift_type=0 -> Out=0x00000008.
- I-type opcode 0010011, funct 000, add_rshift_type=1, A=10, B=3 -> ALUop=0 (ADD), Out=0x0000000D.
- Shifts, funct 101, A=0x80000000, B=0x00000024 (shift 4):
  - add_rshift_type=1 -> Out=0xF8000000.
  - add_rshift_type=0 -> Out=0x08000000.
- Compares, A=0x80000000, B=0x00000001:
  - funct 010 -> Out=1.
  - funct 011 -> Out=0.
- Other opcodes:
  - LUI, A=0x1234, B=0xABCDE000 -> Out=0xABCDE000.
  - Store, A=0x100, B=0xFFFFFFFC -> Out=0x000000FC.
  - Opcode 1111111 -> ALUop=15, Out=0.
